// File: rtl/pxl_pkg.sv
// Shared pixel-stream constants and capture FSM encoding.
// Imported by the conv blocks and the frame-capture sink.
package pxl_pkg;

  localparam int PXL_W   = 8;
  localparam int FRAME_W = 220;
  localparam int FRAME_H = 220;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/pxl_raster_cnt.sv
// Raster column/row/address counter for one W*H frame.
// Ports: clk, reset, clear, step -> col, row, addr, last.
module pxl_raster_cnt
  import pxl_pkg::*;
#(
  parameter int W      = FRAME_W,
  parameter int H      = FRAME_H,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  output logic [7:0]        col,
  output logic [7:0]        row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == 8'(W - 1));
  assign row_end = (row == 8'(H - 1));
  assign last    = col_end && row_end;

  // addr tracks row*W+col by incrementing alongside col.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (step) begin
      addr <= addr + ADDR_W'(1);
      if (col_end) begin
        col <= '0;
        if (!row_end)
          row <= row + 8'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

endmodule

// File: rtl/pxl_frame_capture.sv
// Pixel-stream sink: captures one W*H frame into a frame-buffer write port.
// Ports: clk, reset, start, pxl_in/pxl_valid -> mem_*, col, row, busy, frame_done, drop, pxl_count.
module pxl_frame_capture
  import pxl_pkg::*;
#(
  parameter int W      = FRAME_W,
  parameter int H      = FRAME_H,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PXL_W-1:0]  pxl_in,
  input  logic              pxl_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PXL_W-1:0]  mem_wdata,
  output logic [7:0]        col,
  output logic [7:0]        row,
  output logic              busy,
  output logic              frame_done,
  output logic              drop,
  output logic [ADDR_W-1:0] pxl_count
);

  state_t state_q;
  state_t state_d;

  logic [7:0]        c_col;
  logic [7:0]        c_row;
  logic [ADDR_W-1:0] c_addr;
  logic              c_last;
  logic              arm;
  logic              accept;

  assign arm    = (state_q == ST_IDLE) && start;
  assign accept = (state_q == ST_CAPTURE) && pxl_valid;

  pxl_raster_cnt #(
    .W      (W),
    .H      (H),
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (arm),
    .step  (accept),
    .col   (c_col),
    .row   (c_row),
    .addr  (c_addr),
    .last  (c_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_CAPTURE;
      ST_CAPTURE: if (accept && c_last) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      col        <= '0;
      row        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      drop       <= 1'b0;
      pxl_count  <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d == ST_CAPTURE);
      frame_done <= (state_q == ST_DONE);
      mem_we     <= accept;
      if (accept) begin
        mem_addr  <= c_addr;
        mem_wdata <= pxl_in;
        col       <= c_col;
        row       <= c_row;
        pxl_count <= c_addr + ADDR_W'(1);
      end
      if (arm)
        pxl_count <= '0;
      // A pixel coinciding with start is out-of-frame, so it re-sets drop.
      if (arm)
        drop <= pxl_valid;
      else if (pxl_valid && state_q != ST_CAPTURE)
        drop <= 1'b1;
    end
  end

endmodule

// File: doc/pxl_frame_capture.md
Name: pxl_frame_capture

Overview:
- Sink end of the pixel-stream interface driven by the convolution blocks (`pxl_out` / `valid`).
- Collects exactly one W*H frame of valid pixels and writes each pixel to a frame-buffer RAM write port at a raster address.
- Tracks the column and row of each pixel, pulses `frame_done` when the frame completes, and flags pixels that arrive while not capturing.
- Sits between a conv stage and the frame buffer the host reads back.

Parameters:
- W, 220, frame width in pixels
- H, 220, frame height in pixels
- ADDR_W, 16, frame-buffer address width; must satisfy 2^ADDR_W >= W*H

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse that arms the capture of one frame
- pxl_in  input  8  pixel from the upstream conv block
- pxl_valid  input  1  `pxl_in` is a valid pixel this cycle
- mem_we  output  1  frame-buffer write enable
- mem_addr  output  ADDR_W  frame-buffer write address (raster order)
- mem_wdata  output  8  frame-buffer write data
- col  output  8  column of the pixel currently being written
- row  output  8  row of the pixel currently being written
- busy  output  1  high while in CAPTURE
- frame_done  output  1  one-cycle pulse after the last pixel is written
- drop  output  1  sticky: a valid pixel arrived outside CAPTURE
- pxl_count  output  ADDR_W  number of pixels written in the current/last frame

Behaviour:
- Reset (synchronous, active-high, checked before all other logic):
  - state=IDLE.
  - `mem_we`, `mem_addr`, `mem_wdata`, `col`, `row`, `busy`, `frame_done`, `drop`, `pxl_count` all 0.
  - Reset mid-frame abandons the frame; no `frame_done` is issued.
- States: IDLE, CAPTURE, DONE.
  - IDLE -> CAPTURE on `start`. On that edge: internal address, column and row counters cleared, `pxl_count` cleared, `drop` cleared.
  - CAPTURE -> DONE on the cycle the pixel with index W*H-1 is accepted.
  - DONE -> IDLE unconditionally after one cycle. `frame_done`=1 for exactly that cycle.
- Capture:
  - In CAPTURE, each cycle with `pxl_valid`=1 is accepted. On the next edge the block registers `mem_we`=1, `mem_addr`=current address, `mem_wdata`=`pxl_in`, `col`/`row`=current column/row.
  - Write latency is 1 clock from the accepted input to `mem_we`.
  - Cycles with `pxl_valid`=0 register `mem_we`=0 and hold `mem_addr`/`mem_wdata`/`col`/`row`. Gaps of any length are allowed.
- Counters:
  - Column increments per accepted pixel and wraps W-1 -> 0; on the wrap, row increments.
  - Row reaches H-1 on the final row and is not incremented past it.
  - Address = row*W+col, kept as an incrementing counter (no multiplier). `pxl_count` = address+1 after each write.
  - Last pixel: `mem_addr`=W*H-1, `col`=W-1, `row`=H-1. The frame_done cycle follows that write cycle.
- `busy` = (state==CAPTURE), registered.
- `drop`: set when `pxl_valid`=1 in IDLE or DONE; remains set until the next accepted `start` or reset. Pixels arriving outside CAPTURE are never written.
- `start` while in CAPTURE or DONE is ignored, with no restart.
- `start` and `pxl_valid` in the same IDLE cycle: the pixel is treated as out-of-frame. `drop` is first cleared by the start, then set by this pixel, so `drop`=1. The pixel is not written; the first written pixel is the next valid one.
- Widths: `col`/`row` are 8 bits, so W,H <= 256 (instantiation requirement). All counters are unsigned.

Decomposition:
- Shared package `pxl_pkg`:
  - state encoding localparams ST_IDLE=0, ST_CAPTURE=1, ST_DONE=2;
  - default W/H frame constants (220) shared with the conv blocks;
  - pixel width constant PXL_W=8.
- One natural sub-module `pxl_raster_cnt`:
  - clear and step inputs;
  - col/row/addr outputs;
  - `last` flag asserted when col=W-1 and row=H-1.

Test Plan:
- Reset mid-frame: W=4, H=3, start, 5 valid pixels, assert reset -> all outputs 0 next cycle, state IDLE, no `frame_done`. A new start then captures from `mem_addr`=0.
- Full frame, continuous valid: W=4, H=3, start, then 12 consecutive pixels 0x10..0x1B -> `mem_we` for 12 cycles; addr 0..11; data 0x10..0x1B; col 0,1,2,3,0..; row 0,0,0,0,1..2. `frame_done` one cycle after the addr-11 write; `pxl_count`=12.
- Gapped valid: same frame with `pxl_valid` toggling 1,0,1,0 -> addresses still 0..11 contiguous, `mem_we` low on gap cycles, `frame_done` once.
- Drop detection: valid pixel in IDLE -> `drop`=1 and no write. Next start -> `drop`=0. Valid after `frame_done` -> `drop`=1.
- Ignored restart: start asserted at pixel 6 of a 12-pixel frame -> addresses continue 6..11, single `frame_done`.
- Default size: W=H=220 fed by a counting pattern -> last write `mem_addr`=48399, `col`=219, `row`=219, `pxl_count`=48400.
